// File: rtl/calc_pkg.sv
// Shared definitions for the binary-to-decimal ASCII formatter: FSM states,
// digit count, character codes and a digit selector helper.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SIGN,
    EMIT
  } state_t;

  localparam int          NUM_DIGITS  = 10;
  localparam int          BCD_W       = 4 * NUM_DIGITS;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_MINUS = 8'h2D;

  // Selects one BCD digit by index using constant slices only.
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd, input logic [3:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 4'(i)) d = bcd[i*4 +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/int_to_ascii.sv
// Formats a 32-bit binary value as a decimal ASCII character stream with an
// optional leading '-', using a 32-step double-dabble conversion.
module int_to_ascii
  import calc_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  state_t             state_q;
  logic               sign_q;
  logic [31:0]        mag_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [4:0]         cnt_q;
  logic [3:0]         digit_q;
  logic [7:0]         out_data_q;
  logic               out_last_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [31:0]        mag_d;
  logic [3:0]         msd_d;
  logic               in_sign;
  logic [31:0]        in_mag;
  logic [3:0]         digit_prev;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .d_i(bcd_q[gi*4 +: 4]),
        .d_o(bcd_adj[gi*4 +: 4])
      );
    end
  endgenerate

  assign bcd_d      = {bcd_adj[BCD_W-2:0], mag_q[31]};
  assign mag_d      = {mag_q[30:0], 1'b0};
  assign in_sign    = in_value[31] && SIGNED_IN;
  assign in_mag     = in_sign ? (~in_value + 32'd1) : in_value;
  assign digit_prev = digit_q - 4'd1;

  // Most-significant nonzero digit of the post-step BCD value; 0 when all zero.
  always_comb begin
    msd_d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_d[i*4 +: 4] != 4'd0) msd_d = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      digit_q    <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            mag_q   <= in_mag;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            digit_q <= msd_d;
            if (sign_q) begin
              state_q    <= SIGN;
              out_data_q <= ASCII_MINUS;
              out_last_q <= 1'b0;
            end else begin
              state_q    <= EMIT;
              out_data_q <= ASCII_ZERO + {4'd0, digit_at(bcd_d, msd_d)};
              out_last_q <= (msd_d == 4'd0);
            end
          end
        end
        SIGN: begin
          if (out_ready) begin
            state_q    <= EMIT;
            out_data_q <= ASCII_ZERO + {4'd0, digit_at(bcd_q, digit_q)};
            out_last_q <= (digit_q == 4'd0);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (digit_q == 4'd0) begin
              state_q    <= IDLE;
              out_data_q <= '0;
              out_last_q <= 1'b0;
            end else begin
              digit_q    <= digit_prev;
              out_data_q <= ASCII_ZERO + {4'd0, digit_at(bcd_q, digit_prev)};
              out_last_q <= (digit_prev == 4'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SIGN) || (state_q == EMIT);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
